// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-serial RAM arbiter: FSM states, access sizes, owners.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // Byte count for a size code; 10 and 11 both mean a full word.
  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    case (size)
      SIZE_B:  size_to_n = 3'd1;
      SIZE_H:  size_to_n = 3'd2;
      default: size_to_n = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_assembler.sv
// Collects RAM bytes little-endian into a word and zero/sign-extends to N bytes.
module mem_byte_assembler
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        cap,
  input  logic [1:0]  idx,
  input  logic [7:0]  din,
  input  logic [2:0]  nbytes,
  input  logic        sgn,
  output logic [31:0] word
);

  logic [3:0][7:0] byte_q, byte_d;

  // word includes the byte arriving this cycle so the caller can register it
  // on the same edge as the final capture.
  always_comb begin
    byte_d = byte_q;
    if (cap) byte_d[idx] = din;
  end

  always_ff @(posedge clk) begin
    if (rst)     byte_q <= ZeroWord;
    else if (en) byte_q <= byte_d;
  end

  always_comb begin
    case (nbytes)
      3'd1:    word = {{24{sgn & byte_d[0][7]}}, byte_d[0]};
      3'd2:    word = {{16{sgn & byte_d[1][7]}}, byte_d[1], byte_d[0]};
      default: word = byte_d;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the byte-wide RAM port between IF and MEM, serializing 1/2/4-byte accesses.
// Build option MEMARB_SIGNEXT_EN: sign-extend MEM loads when mem_signed is set.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic              mem_signed,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  state_t            state, state_nxt;
  logic [2:0]        cnt;
  logic              own_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        n_q;
  logic [3:0][7:0]   wdata_q;
  logic              sgn_q;
  logic              sgn_in;
  logic              drive;
  logic              cap;
  logic              last_rd;
  logic [31:0]       word;

`ifdef MEMARB_SIGNEXT_EN
  assign sgn_in = mem_signed;
`else
  logic unused_signed;
  assign unused_signed = mem_signed;
  assign sgn_in        = 1'b0;
`endif

  // Cycle c of a transaction (c = cnt) drives byte c-1 and captures byte c-2.
  assign drive   = (cnt != 3'd0) && (cnt <= n_q);
  assign cap     = (state == ST_READ) && (cnt >= 3'd2) && (cnt <= n_q + 3'd1);
  assign last_rd = (state == ST_READ) && (cnt == n_q + 3'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 3'd0;
    end else if (rdy) begin
      state <= state_nxt;
      cnt   <= (state == ST_READ || state == ST_WRITE) ? cnt + 3'd1 : 3'd0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (mem_req)     state_nxt = mem_we ? ST_WRITE : ST_READ;
        else if (if_req) state_nxt = ST_READ;
      end
      ST_READ:  if (cnt == n_q + 3'd1) state_nxt = ST_DONE;
      ST_WRITE: if (cnt == n_q)        state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_addr = '0;
    ram_wr   = 1'b0;
    ram_dout = 8'h00;
    if_done  = 1'b0;
    mem_done = 1'b0;
    if ((state == ST_READ || state == ST_WRITE) && drive)
      ram_addr = addr_q + ADDR_W'(cnt - 3'd1);
    if (state == ST_WRITE && drive) begin
      ram_wr   = rdy;
      ram_dout = wdata_q[2'(cnt - 3'd1)];
    end
    if (state == ST_DONE) begin
      if (own_q == OWN_MEM) mem_done = 1'b1;
      else                  if_done  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      own_q     <= OWN_IF;
      addr_q    <= '0;
      n_q       <= 3'd4;
      wdata_q   <= ZeroWord;
      sgn_q     <= 1'b0;
      if_data   <= ZeroWord;
      mem_rdata <= ZeroWord;
    end else if (rdy) begin
      if (state == ST_IDLE) begin
        if (mem_req) begin
          own_q   <= OWN_MEM;
          addr_q  <= mem_addr;
          n_q     <= size_to_n(mem_size);
          wdata_q <= mem_wdata;
          sgn_q   <= sgn_in;
        end else if (if_req) begin
          own_q   <= OWN_IF;
          addr_q  <= if_addr;
          n_q     <= 3'd4;
          sgn_q   <= 1'b0;
        end
      end
      if (last_rd) begin
        if (own_q == OWN_MEM) mem_rdata <= word;
        else                  if_data   <= word;
      end
    end
  end

  mem_byte_assembler u_asm (
    .clk    (clk),
    .rst    (rst),
    .en     (rdy),
    .cap    (cap),
    .idx    (2'(cnt - 3'd2)),
    .din    (ram_din),
    .nbytes (n_q),
    .sgn    (sgn_q),
    .word   (word)
  );

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the single byte-wide RAM port between two requesters: instruction fetch (IF) and the MEM stage that handles EX-issued loads and stores.
- Serializes 1/2/4-byte accesses into per-byte RAM cycles, assembles read words little-endian and returns each result with a one-cycle done pulse.
- Sits between the pipeline (IF, MEM) and the top-level RAM/IO bus.

Parameters:
- ADDR_W, 32, address width for requester and RAM addresses.
- DATA_W, 32, requester data width; must be 32.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rdy  in  1  global enable; low freezes the block
- if_req  in  1  IF fetch request; level, held until if_done
- if_addr  in  32  fetch address
- if_data  out  32  fetched instruction word
- if_done  out  1  one-cycle pulse; if_data valid this cycle
- mem_req  in  1  MEM request; level, held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_size  in  2  00 = 1 B, 01 = 2 B, 10/11 = 4 B
- mem_signed  in  1  load sign-extend request (see Optional Feature)
- mem_addr  in  32  byte address from EX
- mem_wdata  in  32  store data; low bytes are used
- mem_rdata  out  32  load result
- mem_done  out  1  one-cycle pulse; load data valid or store complete
- ram_addr  out  32  RAM byte address
- ram_wr  out  1  RAM write strobe
- ram_dout  out  8  RAM write byte
- ram_din  in  8  RAM read byte; valid the cycle after its address is driven

Behaviour:
- Reset: rst is synchronous, active-high. On reset all outputs are 0 and the FSM goes to IDLE. Reset mid-transaction aborts it: no done pulse, partial data discarded, and ram_wr is 0 from the next cycle.
- rdy = 0: all registers hold and ram_wr is forced to 0. The RAM is frozen by the same rdy, so byte alignment is preserved.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: samples requests at the clock edge.
  - mem_req has fixed priority over if_req.
  - An in-flight transaction is never preempted.
  - Captures owner, addr, size (N = 1, 2 or 4; IF is always 4) and wdata.
  - Moves to READ or WRITE.
- Acceptance edge is E0. Cycle k means the cycle after edge Ek.
- READ:
  - Byte i address (addr+i) is driven during cycle i+1, i = 0..N-1.
  - Byte i is captured from ram_din at the end of cycle i+2 into bits [8i+7:8i].
  - After the last capture, go to DONE.
- WRITE:
  - ram_wr = 1, ram_addr = addr+i, ram_dout = wdata[8i+7:8i] during cycle i+1.
  - After byte N-1, go to DONE with ram_wr = 0.
- DONE (one cycle):
  - Owner's done = 1 and data output is valid: loads in cycle N+2, stores in cycle N+1.
  - Requests are ignored in this cycle. The requester must drop req in this cycle.
  - Next state is IDLE.
- Data outputs hold their last value between transactions. Unused upper bytes are 0 (zero-extend).
- Addresses increment modulo 2^32 (0xFFFFFFFF+1 = 0). Misaligned addresses are legal.
- ram_wr is never 1 outside WRITE.
- Simultaneous if_req and mem_req: MEM is served first, IF next. IF may wait indefinitely while MEM keeps requesting; this is acceptable because the pipeline stalls.

Optional Feature:
- Macro MEMARB_SIGNEXT_EN.
- Defined: for loads with mem_signed = 1, mem_rdata is sign-extended from bit 8N-1 (LB, LH). mem_signed = 0 zero-extends.
- Undefined: mem_signed is ignored and all loads zero-extend (EX/MEM handles extension).
- IF data is unaffected either way.

Decomposition:
- Shared defines: state encodings, size codes (SIZE_B, SIZE_H, SIZE_W), owner codes (OWN_IF, OWN_MEM), ZeroWord.
- One natural sub-module: mem_byte_assembler. It covers byte capture and shift/extend given N and mem_signed, and is reused by a later I-cache.

Test Plan:
- IF alone, if_addr = 0x100, RAM[0x100..0x103] = 13,05,00,00 -> if_done cycle 6, if_data = 0x00000513, ram_wr always 0.
- Store SW mem_addr = 0x2000, wdata = 0xDEADBEEF -> ram_wr = 1 cycles 1–4 with bytes EF,BE,AD,DE at 0x2000..0x2003; mem_done cycle 5.
- if_req and mem_req (LW 0x2000) asserted the same edge -> MEM done first with 0xDEADBEEF; IF accepted after DONE/IDLE and finishes later; no overlap of RAM usage.
- LB at 0x2003 (0xDE), mem_signed = 1 -> 0xFFFFFFDE with MEMARB_SIGNEXT_EN defined, 0x000000DE without; LH at 0xFFFFFFFF wraps the second byte to address 0.
- rst asserted in cycle 2 of SW -> ram_wr = 0 next cycle, no mem_done; a fresh request afterwards completes normally.
- rdy low for 3 cycles mid-read -> ram_addr and state hold; completion is delayed exactly 3 cycles with correct data.
